// File: rtl/ivl_uvm_ovl_mclk_gen.sv
// Multi-channel divided-clock pattern generator. Each channel runs a period/high-time
// counter whose configuration is shadowed and only applied at a period boundary.
module ivl_uvm_ovl_mclk_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic              cfg_en,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic              cfg_err
);

  logic [CNT_W-1:0]  s_div_q  [NUM_CH];
  logic [CNT_W-1:0]  s_high_q [NUM_CH];
  logic [CNT_W-1:0]  w_div_q  [NUM_CH];
  logic [CNT_W-1:0]  w_high_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [NUM_CH-1:0] s_en_q, active_q, pend_q, clk_out_q, tick_q;
  logic              err_q;

  logic [CNT_W-1:0]  s_div_d  [NUM_CH];
  logic [CNT_W-1:0]  s_high_d [NUM_CH];
  logic [CNT_W-1:0]  w_div_d  [NUM_CH];
  logic [CNT_W-1:0]  w_high_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] s_en_d, active_d, pend_d, clk_out_d, tick_d;
  logic              err_d;

  logic wr_ok;
  logic hit;
  logic at_bnd;

  // A write is legal only if it names an existing channel and describes a
  // waveform with at least one high and one low cycle.
  assign wr_ok = cfg_wr
              && (32'(cfg_ch) < NUM_CH)
              && (cfg_div >= CNT_W'(2))
              && (cfg_high != '0)
              && (cfg_high < cfg_div);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the loop can leave a signal unassigned and infer a latch.
    s_div_d   = s_div_q;
    s_high_d  = s_high_q;
    s_en_d    = s_en_q;
    w_div_d   = w_div_q;
    w_high_d  = w_high_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pend_d    = pend_q;
    clk_out_d = '0;
    tick_d    = '0;
    err_d     = cfg_wr && !wr_ok;
    hit       = 1'b0;
    at_bnd    = 1'b0;

    for (int i = 0; i < NUM_CH; i++) begin
      // NOTE: blocking assignments here let later lines see the updated shadow
      // values in the same cycle, which is what gives write-through at a boundary.
      hit = wr_ok && (32'(cfg_ch) == i);
      if (hit) begin
        s_div_d[i]  = cfg_div;
        s_high_d[i] = cfg_high;
        s_en_d[i]   = cfg_en;
        pend_d[i]   = 1'b1;
      end

      at_bnd = !active_q[i] || (cnt_q[i] == w_div_q[i] - CNT_W'(1));

      if (sync_all || at_bnd) begin
        cnt_d[i] = '0;
        if (pend_d[i]) begin
          w_div_d[i]  = s_div_d[i];
          w_high_d[i] = s_high_d[i];
          active_d[i] = s_en_d[i];
          pend_d[i]   = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      // Outputs are derived from next state and registered alongside it.
      clk_out_d[i] = active_d[i] && (cnt_d[i] < w_high_d[i]);
      tick_d[i]    = active_d[i] && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel register arrays are reset too; they are small and a
      // defined post-reset configuration keeps idle channels predictable.
      for (int i = 0; i < NUM_CH; i++) begin
        s_div_q[i]  <= CNT_W'(2);
        s_high_q[i] <= CNT_W'(1);
        w_div_q[i]  <= CNT_W'(2);
        w_high_q[i] <= CNT_W'(1);
        cnt_q[i]    <= '0;
      end
      s_en_q    <= '0;
      active_q  <= '0;
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      s_div_q   <= s_div_d;
      s_high_q  <= s_high_d;
      s_en_q    <= s_en_d;
      w_div_q   <= w_div_d;
      w_high_q  <= w_high_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      err_q     <= err_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign active   = active_q;
  assign cfg_pend = pend_q;
  assign cfg_err  = err_q;

endmodule
